// File: rtl/mul4_rr_scheduler.sv
// mul4_rr_scheduler
// One combinational 4x4 unsigned multiplier shared among NREQ requesters.
// A round-robin arbiter picks at most one operand pair per cycle. The product,
// tagged with the winning requester index, lands in a single-entry output
// register that drains through a valid/ready handshake.
module mul4_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*4-1:0] req_a,
  input  logic [NREQ*4-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_prod,
  output logic [IDW-1:0]    out_id,
  output logic [CNTW-1:0]   op_count
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_prod_q, out_prod_d;
  logic [IDW-1:0]  out_id_q, out_id_d;
  logic [CNTW-1:0] op_count_q, op_count_d;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [3:0]      win_a;
  logic [3:0]      win_b;
  logic [7:0]      win_prod;
  logic            issue;
  logic [NREQ-1:0] grant;
  int              scan_idx;

  // Search requesters starting at ptr and wrapping; the first valid one wins
  // and its operand pair is steered to the multiplier.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_a     = '0;
    win_b     = '0;
    scan_idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(scan_idx);
        win_a     = req_a[scan_idx*4 +: 4];
        win_b     = req_b[scan_idx*4 +: 4];
      end
    end
  end

  // The shared multiplier: zero-extended operands give the full 8-bit product.
  always_comb begin
    win_prod = {4'b0000, win_a} * {4'b0000, win_b};
  end

  // Issue only when enabled, someone is asking, the output slot is free or
  // draining this cycle, and reset is not held; the grant is a one-hot of the winner.
  always_comb begin
    issue = rst_n & en & win_found & (~out_valid_q | out_ready);
    grant = '0;
    if (issue) begin
      grant[win_id] = 1'b1;
    end
  end

  // Next-state: an issue reloads the output register and advances the pointer
  // and counter; otherwise an accepted result just clears the valid flag.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_prod_d  = out_prod_q;
    out_id_d    = out_id_q;
    op_count_d  = op_count_q;
    if (issue) begin
      out_valid_d = 1'b1;
      out_prod_d  = win_prod;
      out_id_d    = win_id;
      ptr_d       = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
      op_count_d  = op_count_q + CNTW'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset; reset discards any result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      out_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
      out_id_q    <= out_id_d;
      op_count_q  <= op_count_d;
    end
  end

  // Drive the outputs straight from the registers and the combinational grant.
  always_comb begin
    req_ready = grant;
    out_valid = out_valid_q;
    out_prod  = out_prod_q;
    out_id    = out_id_q;
    op_count  = op_count_q;
  end

endmodule

// File: tb/tb_mul4_rr_scheduler.sv
// tb_mul4_rr_scheduler
// Directed scenarios followed by random traffic, all compared against a
// behavioural model of the shared-multiplier scheduler. A second instance with
// a 4-bit counter watches the operation counter wrap.
module tb_mul4_rr_scheduler;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        out_ready;

  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_prod;
  logic [1:0]  out_id;
  logic [15:0] op_count;

  logic [3:0]  req_ready4;
  logic        out_valid4;
  logic [7:0]  out_prod4;
  logic [1:0]  out_id4;
  logic [3:0]  op_count4;

  int tests_run  = 0;
  int fail_count = 0;

  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_valid = 1'b0;
  int m_prod  = 0;
  int m_id    = 0;

  logic [3:0] last_ready;

  mul4_rr_scheduler #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .out_id(out_id), .op_count(op_count)
  );

  mul4_rr_scheduler #(.NREQ(4), .IDW(2), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_prod(out_prod4),
    .out_id(out_id4), .op_count(op_count4)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Round-robin search from the model pointer; -1 when nobody is valid.
  function automatic int find_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, check the grant, clock, advance the model, check outputs.
  task automatic applyStimulus(input bit r, input bit e, input logic [3:0] v,
                               input logic [15:0] a, input logic [15:0] b, input bit ordy);
    int w;
    bit can_issue;
    logic [3:0] exp_rdy;
    rst_n = r; en = e; req_valid = v; req_a = a; req_b = b; out_ready = ordy;
    #1;
    w = find_winner();
    can_issue = r && e && (w >= 0) && (!m_valid || ordy);
    exp_rdy = can_issue ? (4'b0001 << w) : 4'b0000;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_rdy));
    checkOutput("req_ready_c4", 32'(req_ready4), 32'(exp_rdy));
    last_ready = req_ready;
    @(posedge clk);
    if (!r) begin
      m_ptr = 0; m_cnt = 0; m_valid = 1'b0; m_prod = 0; m_id = 0;
    end else if (can_issue) begin
      m_prod  = int'((a >> (4 * w)) & 16'hF) * int'((b >> (4 * w)) & 16'hF);
      m_id    = w;
      m_valid = 1'b1;
      m_ptr   = (w + 1) % NREQ;
      m_cnt   = m_cnt + 1;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("out_prod", 32'(out_prod), 32'(m_prod));
    checkOutput("out_id", 32'(out_id), 32'(m_id));
    checkOutput("op_count", 32'(op_count), 32'(m_cnt % 65536));
    checkOutput("op_count_c4", 32'(op_count4), 32'(m_cnt % 16));
    checkOutput("out_prod_c4", 32'(out_prod4), 32'(m_prod));
  endtask

  logic [3:0] t3_grants [5];
  logic [15:0] held_prod;

  initial begin
    t3_grants = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset held two cycles with every requester asking.
    applyStimulus(0, 1, 4'b1111, 16'hFFFF, 16'hFFFF, 1);
    applyStimulus(0, 1, 4'b1111, 16'hFFFF, 16'hFFFF, 1);
    checkOutput("t1_ready", 32'(last_ready), 32'h0);
    checkOutput("t1_valid", 32'(out_valid), 32'h0);
    checkOutput("t1_count", 32'(op_count), 32'h0);

    // Single requester with the maximum operands.
    applyStimulus(1, 1, 4'b0010, 16'h00F0, 16'h00F0, 1);
    checkOutput("t2_ready", 32'(last_ready), 32'h2);
    checkOutput("t2_prod", 32'(out_prod), 32'hE1);
    checkOutput("t2_id", 32'(out_id), 32'h1);
    checkOutput("t2_count", 32'(op_count), 32'h1);

    // Fairness: all valid after reset gives grants 0,1,2,3,0.
    applyStimulus(0, 1, 4'b0000, 16'h0, 16'h0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 4'b1111, 16'h4321, 16'h5678, 1);
      checkOutput("t3_grant", 32'(last_ready), 32'(t3_grants[i]));
      checkOutput("t3_id", 32'(out_id), 32'(i % 4));
    end

    // Backpressure: output held for three cycles, then drain and issue together.
    held_prod = {8'h00, out_prod};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 4'b1111, 16'h9ABC, 16'hDEF1, 0);
      checkOutput("t4_stall_ready", 32'(last_ready), 32'h0);
      checkOutput("t4_stall_prod", 32'(out_prod), 32'(held_prod));
    end
    applyStimulus(1, 1, 4'b1111, 16'h9ABC, 16'hDEF1, 1);
    checkOutput("t4_reissue_valid", 32'(out_valid), 32'h1);
    checkOutput("t4_reissue_ready", 32'(last_ready), 32'h2);

    // Pointer wrap: after a grant to 2, requesters 3 then 0 win.
    applyStimulus(0, 1, 4'b0000, 16'h0, 16'h0, 1);
    applyStimulus(1, 1, 4'b0100, 16'h0700, 16'h0300, 1);
    checkOutput("t5_grant2", 32'(last_ready), 32'h4);
    applyStimulus(1, 1, 4'b1001, 16'hE00D, 16'hB00C, 1);
    checkOutput("t5_grant3", 32'(last_ready), 32'h8);
    checkOutput("t5_prod3", 32'(out_prod), 32'(14 * 11));
    applyStimulus(1, 1, 4'b1001, 16'hE00D, 16'hB00C, 1);
    checkOutput("t5_grant0", 32'(last_ready), 32'h1);
    checkOutput("t5_prod0", 32'(out_prod), 32'(13 * 12));

    // Counter wrap on the 4-bit instance after sixteen issues.
    applyStimulus(0, 1, 4'b0000, 16'h0, 16'h0, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1, 4'b1111, 16'($urandom), 16'($urandom), 1);
    end
    checkOutput("t5_count4_wrap", 32'(op_count4), 32'h0);
    checkOutput("t5_count16", 32'(op_count), 32'd16);

    // Reset while a result is stalled discards it and restarts the pointer.
    applyStimulus(1, 1, 4'b0100, 16'h0500, 16'h0500, 0);
    applyStimulus(1, 1, 4'b1111, 16'h1111, 16'h1111, 0);
    applyStimulus(0, 1, 4'b1111, 16'h1111, 16'h1111, 0);
    checkOutput("t6_valid", 32'(out_valid), 32'h0);
    applyStimulus(1, 1, 4'b1111, 16'h1111, 16'h1111, 1);
    checkOutput("t6_ptr_restart", 32'(last_ready), 32'h1);

    // Freeze issue with en=0 while the pending result drains.
    applyStimulus(1, 0, 4'b1111, 16'h2222, 16'h3333, 1);
    checkOutput("t7_en_low_ready", 32'(last_ready), 32'h0);
    checkOutput("t7_drained", 32'(out_valid), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) != 0),
                    4'($urandom), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
